adjust_repeat_control: RTL
==========================

# adjust_repeat_control

Parametrised press-and-hold controller for clock-field adjustment. Turns a debounced adjust button, a one-hot field-select and a direction bit into single-cycle increment/decrement strobes per field. Behaviour: one strobe on press, then auto-repeat after a hold delay, then accelerated repeat after a set number of slow repeats. Sits between the button/mode front end and the per-field time counters; delays are measured in `tick` enables, not clock cycles.

## Interface
- `NUM_FIELDS`, 3: number of adjustable fields (hours/minutes/seconds = 3; ≥1).
- `HOLD_DELAY_TICKS`, 5: ticks from press strobe to first repeat strobe (≥1).
- `SLOW_PERIOD_TICKS`, 3: ticks between repeats in slow phase (≥1).
- `FAST_PERIOD_TICKS`, 1: ticks between repeats in fast phase (≥1).
- `FAST_AFTER_REPEATS`, 4: slow repeats before switching to fast (0 = fast straight after delay).

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: single-cycle timebase enable.
- `adjust_button` in 1: debounced, clk-synchronous button level.
- `adjust_mode` in NUM_FIELDS: field select, one-hot or all-zero (all-zero = not adjusting).
- `adjust_dir` in 1: 0 = increment, 1 = decrement.
- `increment` out NUM_FIELDS: one-cycle increment strobes, registered.
- `decrement` out NUM_FIELDS: one-cycle decrement strobes, registered.
- `repeating` out 1: high while in REPEAT_SLOW or REPEAT_FAST.

## Operation
- States: IDLE, DELAY, REPEAT_SLOW, REPEAT_FAST. Registers: `mode_latch`, `dir_latch`, tick down-counter `cnt`, saturating repeat counter `rep`.
- "Active" = `adjust_button` high and `adjust_mode` non-zero.
- Strobe: `increment`/`decrement` are driven for one clk with `mode_latch` (per `dir_latch`); the other vector is zero.
- IDLE + active:
  - latch mode and dir;
  - fire a strobe;
  - load `cnt` = HOLD_DELAY_TICKS, `rep` = 0;
  - go to DELAY.
- Any state, not active: go to IDLE and clear `cnt`/`rep`. No strobe.
- Non-IDLE, active, and (`adjust_mode` ≠ `mode_latch` or `adjust_dir` ≠ `dir_latch`): treated as a fresh press. Relatch, fire a strobe on the new field/direction, reload HOLD_DELAY_TICKS, go to DELAY.
- Counting: on `tick`, `cnt` decrements. A tick taking `cnt` 1→0 is an expiry.
- Expiry in DELAY:
  - fire a strobe;
  - if FAST_AFTER_REPEATS = 0: go to REPEAT_FAST, load FAST_PERIOD_TICKS;
  - otherwise: go to REPEAT_SLOW, load SLOW_PERIOD_TICKS.
- Expiry in REPEAT_SLOW:
  - fire a strobe and increment `rep`;
  - if the new `rep` = FAST_AFTER_REPEATS: go to REPEAT_FAST, load FAST_PERIOD_TICKS;
  - otherwise: reload SLOW_PERIOD_TICKS.
- Expiry in REPEAT_FAST: fire a strobe and reload FAST_PERIOD_TICKS. Stay there until release or a field/direction change.
- Priority within one cycle: reset > release > press/change > tick expiry. A tick coinciding with a press, change or release is discarded.
- Multi-hot `adjust_mode` is not checked. Strobes go to every latched bit.
- Widths: `cnt` is $clog2(max period/delay + 1) bits. `rep` is $clog2(FAST_AFTER_REPEATS + 1) bits, minimum 1, and saturates.

## Timing
- Reset (async assert, sync release): IDLE; `increment`, `decrement`, `repeating`, `mode_latch`, `cnt`, `rep` all 0.
- Press latency: active sampled at edge k → strobe visible for the cycle after edge k.
- Button already held at reset release: the first edge with active high counts as a press.
- Repeat spacing: strobe fires in the cycle after the edge that samples the expiring tick. Spacing is exactly N ticks for the phase's N.
- Release latency: in the cycle after the edge sampling release, no strobe is possible and `repeating` is low.
- Strobes never exceed one cycle. Back-to-back strobes occur only when `tick` is asserted on consecutive clocks with a period of 1.

## Structure
- Shared package/header `adjust_pkg`:
  - state encoding (IDLE, DELAY, REPEAT_SLOW, REPEAT_FAST);
  - direction constants DIR_INC = 0 and DIR_DEC = 1.
- Sub-module `adjust_tick_counter`:
  - loadable down-counter with tick enable and an expiry flag;
  - parametrised by width;
  - async active-low clear.
- Top level holds the FSM, latches, repeat counter and output registers.

## Test plan
- Defaults. Press with mode=3'b010, dir=0, and hold for 30 ticks with `tick` every 4 clks:
  - `increment`=010 for one cycle after the press edge;
  - repeats after 5 ticks, then every 3 ticks ×4, then every tick;
  - `decrement` stays 0.
- Press and release after 2 ticks → exactly one strobe, `repeating` never asserts.
- Hold into REPEAT_FAST, switch mode to 100 → strobe `increment`=100 on the next cycle; the next repeat comes 5 ticks later and is slow.
- Hold in REPEAT_SLOW, flip `adjust_dir` → `decrement` strobe on the latched field; the delay restarts.
- `tick` coincident with the press edge and with the release edge → tick ignored; no extra strobe.
- Assert `rst_n` low mid-REPEAT_FAST with the button held:
  - outputs zero immediately;
  - after release of reset, one press strobe on the first edge;
  - repeat after HOLD_DELAY_TICKS.
- FAST_AFTER_REPEATS=0 → straight to FAST_PERIOD_TICKS spacing after the hold delay.

Source files
------------

// File: rtl/adjust_pkg.sv
// Shared definitions for the press-and-hold adjust controller:
// FSM state encoding, direction constants and a small sizing helper.
package adjust_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DELAY       = 2'd1,
    REPEAT_SLOW = 2'd2,
    REPEAT_FAST = 2'd3
  } state_t;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adjust_tick_counter.sv
// Loadable tick-enabled down-counter; expire flags the tick that takes it 1 -> 0.
// Clear beats load, and load beats counting, so the parent can express its priorities directly.
module adjust_tick_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count_reg;

  assign expire = tick && (count_reg == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/adjust_repeat_control.sv
// Press-and-hold adjust controller: one strobe on press, slow auto-repeat after a hold
// delay, then fast repeat. All delays count tick enables; strobes are registered.
module adjust_repeat_control
  import adjust_pkg::*;
#(
  parameter int NUM_FIELDS         = 3,
  parameter int HOLD_DELAY_TICKS   = 5,
  parameter int SLOW_PERIOD_TICKS  = 3,
  parameter int FAST_PERIOD_TICKS  = 1,
  parameter int FAST_AFTER_REPEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  adjust_button,
  input  logic [NUM_FIELDS-1:0] adjust_mode,
  input  logic                  adjust_dir,
  output logic [NUM_FIELDS-1:0] increment,
  output logic [NUM_FIELDS-1:0] decrement,
  output logic                  repeating
);

  localparam int CNT_W = $clog2(max3(HOLD_DELAY_TICKS, SLOW_PERIOD_TICKS, FAST_PERIOD_TICKS) + 1);
  localparam int REP_W = (FAST_AFTER_REPEATS < 1) ? 1 : $clog2(FAST_AFTER_REPEATS + 1);

  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_DELAY_TICKS);
  localparam logic [CNT_W-1:0] SLOW_V = CNT_W'(SLOW_PERIOD_TICKS);
  localparam logic [CNT_W-1:0] FAST_V = CNT_W'(FAST_PERIOD_TICKS);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(FAST_AFTER_REPEATS);

  state_t                  state_reg;
  logic [NUM_FIELDS-1:0]   mode_latch;
  logic                    dir_latch;
  logic [REP_W-1:0]        rep_reg;
  logic [REP_W-1:0]        rep_next;

  logic                    active;
  logic                    changed;
  logic                    press;
  logic                    expiry;
  logic                    cnt_expire;
  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_load_value;

  assign active   = adjust_button && (|adjust_mode);
  assign changed  = (state_reg != IDLE) && ((adjust_mode != mode_latch) || (adjust_dir != dir_latch));
  assign press    = active && ((state_reg == IDLE) || changed);
  // A tick arriving together with a press/change/release is dropped by this gating.
  assign expiry   = active && !press && (state_reg != IDLE) && cnt_expire;
  assign rep_next = (&rep_reg) ? rep_reg : rep_reg + 1'b1;

  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    if (press) begin
      cnt_load       = 1'b1;
      cnt_load_value = HOLD_V;
    end else if (expiry) begin
      cnt_load = 1'b1;
      case (state_reg)
        DELAY:       cnt_load_value = (FAST_AFTER_REPEATS == 0) ? FAST_V : SLOW_V;
        REPEAT_SLOW: cnt_load_value = (rep_next == REP_TARGET) ? FAST_V : SLOW_V;
        default:     cnt_load_value = FAST_V;
      endcase
    end
  end

  adjust_tick_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .clear      (!active),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .expire     (cnt_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mode_latch <= '0;
      dir_latch  <= DIR_INC;
      rep_reg    <= '0;
      increment  <= '0;
      decrement  <= '0;
      repeating  <= 1'b0;
    end else begin
      increment <= '0;
      decrement <= '0;
      if (!active) begin
        state_reg <= IDLE;
        rep_reg   <= '0;
        repeating <= 1'b0;
      end else if (press) begin
        mode_latch <= adjust_mode;
        dir_latch  <= adjust_dir;
        rep_reg    <= '0;
        state_reg  <= DELAY;
        repeating  <= 1'b0;
        increment  <= (adjust_dir == DIR_INC) ? adjust_mode : '0;
        decrement  <= (adjust_dir == DIR_DEC) ? adjust_mode : '0;
      end else if (expiry) begin
        increment <= (dir_latch == DIR_INC) ? mode_latch : '0;
        decrement <= (dir_latch == DIR_DEC) ? mode_latch : '0;
        repeating <= 1'b1;
        case (state_reg)
          DELAY:       state_reg <= (FAST_AFTER_REPEATS == 0) ? REPEAT_FAST : REPEAT_SLOW;
          REPEAT_SLOW: begin
            rep_reg <= rep_next;
            if (rep_next == REP_TARGET) state_reg <= REPEAT_FAST;
          end
          default:     state_reg <= REPEAT_FAST;
        endcase
      end
    end
  end

endmodule
